// File: rtl/mole_match_engine.sv
// Whack-a-mole match engine: turns hole presses into registered hit/miss pulses
// and saturating score counters. Define MOLE_STREAK_EN to add streak tracking.
module mole_match_engine #(
    parameter int NUM_MOLES = 5,
    parameter int HIT_W     = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_MOLES-1:0] molesGenerated,
    input  logic [HIT_W-1:0]     hit,
    output logic [HIT_W-1:0]     moleHit,
    output logic                 moleMiss,
    output logic [CNT_W-1:0]     hitCount,
    output logic [CNT_W-1:0]     missCount
`ifdef MOLE_STREAK_EN
    ,
    output logic [CNT_W-1:0]     streak,
    output logic [CNT_W-1:0]     bestStreak
`endif
);

    localparam logic [HIT_W-1:0] MAX_CODE = HIT_W'(NUM_MOLES);

    logic [HIT_W-1:0]     hit_prev_q, hit_prev_d;
    logic [NUM_MOLES-1:0] whacked_q, whacked_d;
    logic [HIT_W-1:0]     mole_hit_q, mole_hit_d;
    logic                 mole_miss_q, mole_miss_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

    logic [HIT_W-1:0]     hit_san;
    logic [NUM_MOLES-1:0] sel;
    logic                 press, is_hit, is_miss;

    always_comb begin
        hit_san = (hit > MAX_CODE) ? '0 : hit;
        sel     = '0;
        for (int k = 0; k < NUM_MOLES; k++)
            sel[k] = (hit_san == HIT_W'(k + 1));
        press   = (hit_san != '0) && (hit_san != hit_prev_q);
        // molesGenerated is used live, so a mole falling this cycle misses and
        // one rising this cycle (mask already cleared while it was down) hits.
        is_hit  = press && enable && |(sel & molesGenerated & ~whacked_q);
        is_miss = press && enable && !is_hit;

        hit_prev_d  = hit_san;
        whacked_d   = (whacked_q & molesGenerated) | (is_hit ? sel : '0);
        mole_hit_d  = is_hit ? hit_san : '0;
        mole_miss_d = is_miss;
        hit_cnt_d   = (is_hit && hit_cnt_q != '1) ? hit_cnt_q + 1'b1 : hit_cnt_q;
        miss_cnt_d  = (is_miss && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_prev_q  <= '0;
            whacked_q   <= '0;
            mole_hit_q  <= '0;
            mole_miss_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            hit_prev_q  <= hit_prev_d;
            whacked_q   <= whacked_d;
            mole_hit_q  <= mole_hit_d;
            mole_miss_q <= mole_miss_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign moleHit   = mole_hit_q;
    assign moleMiss  = mole_miss_q;
    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;

`ifdef MOLE_STREAK_EN
    logic [CNT_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] streak_inc;

    always_comb begin
        streak_inc = (streak_q == '1) ? streak_q : streak_q + 1'b1;
        streak_d   = streak_q;
        best_d     = best_q;
        if (is_hit) begin
            streak_d = streak_inc;
            if (streak_inc > best_q)
                best_d = streak_inc;
        end else if (is_miss) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q <= '0;
            best_q   <= '0;
        end else begin
            streak_q <= streak_d;
            best_q   <= best_d;
        end
    end

    assign streak     = streak_q;
    assign bestStreak = best_q;
`endif

endmodule

// File: doc/mole_match_engine.md
MOLE_MATCH_ENGINE -- requirements
Module: mole_match_engine

Interface
REQ-001 The block SHALL have parameter NUM_MOLES, default 5, giving the number of mole holes (range 1..15).
REQ-002 The block SHALL have parameter HIT_W, default 3, giving the width of the hit code; the required value is ceil(log2(NUM_MOLES+1)).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the score counters.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: high while a round is running.
REQ-007 The block SHALL have port molesGenerated, input, NUM_MOLES bits: bit k-1 high means mole k is up.
REQ-008 The block SHALL have port hit, input, HIT_W bits: 0 means no press; k (1..NUM_MOLES) means hole k is pressed.
REQ-009 The block SHALL have port moleHit, output, HIT_W bits: a registered one-cycle pulse carrying the index of a successfully hit mole; 0 otherwise.
REQ-010 The block SHALL have port moleMiss, output, 1 bit: a registered one-cycle miss pulse.
REQ-011 The block SHALL have port hitCount, output, CNT_W bits: saturating count of hits.
REQ-012 The block SHALL have port missCount, output, CNT_W bits: saturating count of misses.
REQ-013 The block SHALL have ports streak and bestStreak, outputs, CNT_W bits each, present only under MOLE_STREAK_EN (see Configuration).

Function
REQ-014 The block SHALL sanitise hit: codes greater than NUM_MOLES SHALL be treated as 0.
REQ-015 The block SHALL register the sanitised code as hitPrev on every cycle, including cycles where enable is low.
REQ-016 A press event SHALL occur when the sanitised hit is nonzero and differs from hitPrev.
  - A held code SHALL produce exactly one event.
  - A direct change k->j (k, j nonzero) SHALL produce an event for j.
REQ-017 The block SHALL keep an internal whackedMask of NUM_MOLES bits; mole k is live when molesGenerated[k-1]=1 and whackedMask[k-1]=0.
REQ-018 An event on a live mole k with enable high SHALL cause the following on the next edge:
  - moleHit=k and moleMiss=0;
  - whackedMask[k-1] set;
  - hitCount incremented.
REQ-019 An event with enable high on a hole that is absent or already whacked SHALL cause the following on the next edge:
  - moleHit=0 and moleMiss=1;
  - missCount incremented.
REQ-020 Any cycle with no event, or with enable low, SHALL give moleHit=0 and moleMiss=0 on the next edge; the counters SHALL hold.
REQ-021 Latency SHALL be exactly 1 cycle from the edge sampling the event to the edge presenting moleHit/moleMiss; moleHit and moleMiss SHALL never be nonzero together.
REQ-022 whackedMask[k-1] SHALL clear on any edge where molesGenerated[k-1]=0, so a reappearing mole is live again.
REQ-023 If an event targets mole k in the same cycle molesGenerated[k-1] falls, that event SHALL be a miss.
REQ-024 If an event targets mole k in the same cycle molesGenerated[k-1] rises, that event SHALL be a hit.
REQ-025 hitCount and missCount SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-026 With reset high at an edge, the block SHALL set moleHit=0, moleMiss=0, hitCount=0, missCount=0, whackedMask=0 and hitPrev=0 (plus streak=0 and bestStreak=0 when compiled in).
REQ-027 Reset SHALL take priority over every event and discard any event sampled in the same cycle.
REQ-028 Reset mid-round SHALL leave no pending pulse.
REQ-029 On the first edge after reset, a code already held on hit SHALL count as a new event.

Configuration
REQ-030 With macro MOLE_STREAK_EN defined, the block SHALL behave as follows:
  - streak increments (saturating) on each hit and clears to 0 on each miss;
  - bestStreak updates to streak+1 on the same edge whenever a hit makes streak+1 exceed it.
REQ-031 With MOLE_STREAK_EN undefined, ports streak and bestStreak and their registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Bench SHALL cover: molesGenerated=00101, hit=1 held 4 cycles -> moleHit=1 for exactly one cycle, hitCount=1, further holding gives nothing.
REQ-033 Bench SHALL cover: molesGenerated=00101, hit=2 -> moleMiss pulse one cycle, missCount=1, moleHit=0.
REQ-034 Bench SHALL cover: mole 3 hit, released, hit=3 again while still up -> second press is a miss; drop then raise bit 2, press 3 -> hit, hitCount=2.
REQ-035 Bench SHALL cover: hit=7 with NUM_MOLES=5 -> no pulse, no count change; with enable=0, hit=1 on live mole -> no pulse.
REQ-036 Bench SHALL cover: CNT_W=2, 5 hits -> hitCount stays 3; with MOLE_STREAK_EN, sequence hit,hit,miss,hit -> streak 1,2,0,1 and bestStreak=2.
REQ-037 Bench SHALL cover: reset asserted in the cycle of a valid hit -> all outputs 0 next cycle, no count.
